rv_dmem_resp: RTL and testbench

RV_DMEM_RESP -- requirements
Module: rv_dmem_resp

---
 rtl/rv_dmem_resp_if.sv | 24 ++
 rtl/rv_dmem_resp.sv | 136 +++++++++++++
 tb/tb_rv_dmem_resp.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rv_dmem_resp_if.sv
// Core-to-data-memory handshake bundle: request fields from the core,
// registered completion, error flag and load data back from the memory.
interface rv_dmem_resp_if #(
  parameter int DPWIDTH = 32
) ();
  logic               dmem_req;
  logic               dmem_we;
  logic [3:0]         dmem_be;
  logic [DPWIDTH-1:0] dmem_addr;
  logic [DPWIDTH-1:0] dmem_dataout;
  logic [DPWIDTH-1:0] dmem_datain;
  logic               dmem_ready;
  logic               dmem_err;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_dataout,
    input  dmem_datain, dmem_ready, dmem_err
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_dataout,
    output dmem_datain, dmem_ready, dmem_err
  );
endinterface

// File: rtl/rv_dmem_resp.sv
// Data memory responder: accepts one request at a time in IDLE, waits a fixed
// number of cycles, then performs the byte-masked store or full-word load and
// pulses dmem_ready. Misaligned or out-of-range requests complete with dmem_err
// after the same latency and never touch the memory array.
module rv_dmem_resp #(
  parameter int DPWIDTH    = 32,
  parameter int MEMWORDS   = 256,
  parameter int WAITSTATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  rv_dmem_resp_if.slave bus
);

  localparam int                 AW         = $clog2(MEMWORDS);
  localparam logic [3:0]         WS_LOAD    = (WAITSTATES > 0) ? 4'(WAITSTATES - 1) : 4'd0;
  localparam logic [DPWIDTH-1:0] ADDR_LIMIT = DPWIDTH'(MEMWORDS * 4);
  localparam int                 NBYTES     = (DPWIDTH / 8 < 4) ? DPWIDTH / 8 : 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [DPWIDTH-1:0] data_q, data_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic               bad_q, bad_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [DPWIDTH-1:0] datain_q, datain_d;
  logic               mem_wr;
  logic               req_bad;

  logic [DPWIDTH-1:0] mem_q [MEMWORDS];

  // A request is rejected when not word aligned or beyond the last word.
  assign req_bad = (bus.dmem_addr[1:0] != 2'b00) || (bus.dmem_addr >= ADDR_LIMIT);

  // Next-state logic: latch request in IDLE, count wait states, then respond.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    we_d     = we_q;
    be_d     = be_q;
    bad_d    = bad_q;
    datain_d = datain_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    mem_wr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.dmem_req) begin
          idx_d  = bus.dmem_addr[AW+1:2];
          data_d = bus.dmem_dataout;
          we_d   = bus.dmem_we;
          be_d   = bus.dmem_be;
          bad_d  = req_bad;
          if (WAITSTATES > 0) begin
            // Rejected requests also pass through WAIT so latency is uniform.
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = req_bad ? S_ERR : S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = bad_q ? S_ERR : S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        ready_d = 1'b1;
        mem_wr  = we_q;
        if (!we_q) begin
          datain_d = mem_q[idx_q];
        end
        state_d = S_IDLE;
      end
      S_ERR: begin
        ready_d = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      bad_q    <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      datain_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      we_q     <= we_d;
      be_q     <= be_d;
      bad_q    <= bad_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      datain_q <= datain_d;
    end
  end

  // Memory array is not reset; byte lanes are written only where enabled.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= data_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.dmem_datain = datain_q;
  assign bus.dmem_ready  = ready_q;
  assign bus.dmem_err    = err_q;

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Directed bench for rv_dmem_resp: three instances cover WAITSTATES = 1, 0, 15.
module tb_rv_dmem_resp;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        req_s  [3];
  logic        we_s   [3];
  logic [3:0]  be_s   [3];
  logic [31:0] addr_s [3];
  logic [31:0] wd_s   [3];
  logic [31:0] rd_s   [3];
  logic        rdy_s  [3];
  logic        err_s  [3];

  int n_checks = 0;
  int n_fail   = 0;

  rv_dmem_resp_if #(.DPWIDTH(32)) bus0 ();
  rv_dmem_resp_if #(.DPWIDTH(32)) bus1 ();
  rv_dmem_resp_if #(.DPWIDTH(32)) bus2 ();

  assign bus0.dmem_req = req_s[0];  assign bus0.dmem_we = we_s[0];  assign bus0.dmem_be = be_s[0];
  assign bus0.dmem_addr = addr_s[0]; assign bus0.dmem_dataout = wd_s[0];
  assign rd_s[0] = bus0.dmem_datain; assign rdy_s[0] = bus0.dmem_ready; assign err_s[0] = bus0.dmem_err;

  assign bus1.dmem_req = req_s[1];  assign bus1.dmem_we = we_s[1];  assign bus1.dmem_be = be_s[1];
  assign bus1.dmem_addr = addr_s[1]; assign bus1.dmem_dataout = wd_s[1];
  assign rd_s[1] = bus1.dmem_datain; assign rdy_s[1] = bus1.dmem_ready; assign err_s[1] = bus1.dmem_err;

  assign bus2.dmem_req = req_s[2];  assign bus2.dmem_we = we_s[2];  assign bus2.dmem_be = be_s[2];
  assign bus2.dmem_addr = addr_s[2]; assign bus2.dmem_dataout = wd_s[2];
  assign rd_s[2] = bus2.dmem_datain; assign rdy_s[2] = bus2.dmem_ready; assign err_s[2] = bus2.dmem_err;

  rv_dmem_resp #(.DPWIDTH(32), .MEMWORDS(256), .WAITSTATES(1))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  rv_dmem_resp #(.DPWIDTH(32), .MEMWORDS(256), .WAITSTATES(0))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
  rv_dmem_resp #(.DPWIDTH(32), .MEMWORDS(256), .WAITSTATES(15)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // One request on instance d; lat = rising edges from acceptance to dmem_ready (-1 on timeout).
  task automatic xact(input int d, input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] data, output int lat, output logic err, output logic [31:0] rd);
    @(negedge clk);
    req_s[d] = 1'b1; we_s[d] = we; be_s[d] = be; addr_s[d] = addr; wd_s[d] = data;
    @(posedge clk); #1;
    req_s[d] = 1'b0;
    lat = -1; err = 1'b0; rd = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy_s[d]) begin
        lat = i; err = err_s[d]; rd = rd_s[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++; if (rdy_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d] got %b want 0", d, rdy_s[d]); end
      n_checks++; if (err_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d] got %b want 0", d, err_s[d]); end
      n_checks++; if (rd_s[d] !== 32'h0) begin n_fail++; $display("FAIL reset_datain[%0d] got %h want 0", d, rd_s[d]); end
    end
    rst = 1'b1;
  endtask

  task automatic test_store_load();
    int lat; logic err; logic [31:0] rd;
    xact(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, lat, err, rd);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL st_lat got %0d want 2", lat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL st_err got %b want 0", err); end
    xact(0, 1'b0, 4'b0000, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL ld_lat got %0d want 2", lat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ld_err got %b want 0", err); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_data got %h want deadbeef", rd); end
    @(posedge clk); #1;
    n_checks++; if (rdy_s[0] !== 1'b0) begin n_fail++; $display("FAIL ready_one_cycle got %b want 0", rdy_s[0]); end
  endtask

  task automatic test_byte_store();
    int lat; logic err; logic [31:0] rd;
    xact(0, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, lat, err, rd);
    xact(0, 1'b0, 4'b0000, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL byte_store got %h want deadaaef", rd); end
    xact(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, lat, err, rd);
    n_checks++; if (lat !== 2 || err !== 1'b0) begin n_fail++; $display("FAIL be0_resp got lat=%0d err=%b want lat=2 err=0", lat, err); end
    xact(0, 1'b0, 4'b1111, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL be0_nochange got %h want deadaaef", rd); end
  endtask

  task automatic test_errors();
    int lat; logic err; logic [31:0] rd;
    xact(0, 1'b0, 4'b1111, 32'h12, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 2 || err !== 1'b1) begin n_fail++; $display("FAIL misalign got lat=%0d err=%b want lat=2 err=1", lat, err); end
    n_checks++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL misalign_hold got %h want deadaaef", rd); end
    xact(0, 1'b0, 4'b1111, 32'h400, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 2 || err !== 1'b1) begin n_fail++; $display("FAIL oor got lat=%0d err=%b want lat=2 err=1", lat, err); end
    n_checks++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL oor_hold got %h want deadaaef", rd); end
    xact(0, 1'b1, 4'b1111, 32'h13, 32'h0, lat, err, rd);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL st_misalign_err got %b want 1", err); end
    xact(0, 1'b0, 4'b1111, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'hDEADAAEF || err !== 1'b0) begin n_fail++; $display("FAIL mem_unchanged got %h err=%b want deadaaef err=0", rd, err); end
  endtask

  task automatic test_reset_abort();
    int lat; logic err; logic [31:0] rd;
    int seen;
    xact(0, 1'b1, 4'b1111, 32'h20, 32'h11111111, lat, err, rd);
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; be_s[0] = 4'b1111; addr_s[0] = 32'h20; wd_s[0] = 32'h12345678;
    @(posedge clk); #1;
    req_s[0] = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (rd_s[0] !== 32'h0) begin n_fail++; $display("FAIL abort_datain got %h want 0", rd_s[0]); end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rdy_s[0] !== 1'b0) seen++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rdy_s[0] !== 1'b0) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_ready got %0d pulses want 0", seen); end
    xact(0, 1'b0, 4'b1111, 32'h20, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL abort_ld_lat got %0d want 2", lat); end
    n_checks++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL abort_prior got %h want 11111111", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic err; logic [31:0] rd;
    int pulses;
    xact(1, 1'b1, 4'b1111, 32'h10, 32'hCAFEF00D, lat, err, rd);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ws0_st_lat got %0d want 1", lat); end
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b0; be_s[1] = 4'b0000; addr_s[1] = 32'h10;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rdy_s[1] !== ((i % 2) == 0)) begin n_fail++; $display("FAIL b2b_ready edge %0d got %b want %b", i, rdy_s[1], ((i % 2) == 0)); end
      if (rdy_s[1] === 1'b1) pulses++;
      if (i == 6) req_s[1] = 1'b0;
    end
    n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", pulses); end
    n_checks++; if (rd_s[1] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_data got %h want cafef00d", rd_s[1]); end
    repeat (2) @(posedge clk); #1;
    n_checks++; if (rdy_s[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_stop got %b want 0", rdy_s[1]); end
  endtask

  task automatic test_req_toggle();
    int lat; logic err; logic [31:0] rd;
    int pulses;
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; be_s[0] = 4'b1111; addr_s[0] = 32'h14; wd_s[0] = 32'h00000055;
    @(posedge clk); #1;
    req_s[0] = 1'b0; addr_s[0] = 32'h18; wd_s[0] = 32'hFFFFFFFF; we_s[0] = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rdy_s[0] !== 1'b0) begin n_fail++; $display("FAIL toggle_early got %b want 0", rdy_s[0]); end
    req_s[0] = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rdy_s[0] !== 1'b1 || err_s[0] !== 1'b0) begin n_fail++; $display("FAIL toggle_ready got %b err=%b want 1 err=0", rdy_s[0], err_s[0]); end
    req_s[0] = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rdy_s[0] === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL toggle_double got %0d extra pulses want 0", pulses); end
    xact(0, 1'b0, 4'b1111, 32'h14, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h00000055) begin n_fail++; $display("FAIL latched_fields got %h want 00000055", rd); end
  endtask

  task automatic test_ws15();
    int lat; logic err; logic [31:0] rd;
    xact(2, 1'b1, 4'b1111, 32'h3FC, 32'hA5A55A5A, lat, err, rd);
    n_checks++; if (lat !== 16 || err !== 1'b0) begin n_fail++; $display("FAIL ws15_st got lat=%0d err=%b want lat=16 err=0", lat, err); end
    xact(2, 1'b0, 4'b0000, 32'h3FC, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL ws15_ld_lat got %0d want 16", lat); end
    n_checks++; if (rd !== 32'hA5A55A5A) begin n_fail++; $display("FAIL ws15_ld_data got %h want a5a55a5a", rd); end
    xact(2, 1'b0, 4'b1111, 32'h400, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 16 || err !== 1'b1) begin n_fail++; $display("FAIL ws15_oor got lat=%0d err=%b want lat=16 err=1", lat, err); end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      req_s[d] = 1'b0; we_s[d] = 1'b0; be_s[d] = 4'b0000; addr_s[d] = 32'h0; wd_s[d] = 32'h0;
    end
    test_reset();
    test_store_load();
    test_byte_store();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_req_toggle();
    test_ws15();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
